// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage around a 16-bit ALU with an 8 x 16 register file (r0 reads 0).
// Define ALU_ISSUE_BYPASS_EN to forward the in-flight result on RAW hazards instead of stalling one cycle.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [10:0] ins,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_o,
  input  logic        alu_cout,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_cout,
  output logic [2:0]  res_rd,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [15:0] regs [0:7];
  logic        ex_valid;
  logic [2:0]  ex_rd;

  logic [1:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;
  logic        hazard1;
  logic        hazard2;
  logic        stall;
  logic        issue;

  assign op  = ins[10:9];
  assign rd  = ins[8:6];
  assign rs1 = ins[5:3];
  assign rs2 = ins[2:0];

  assign rd1 = (rs1 == 3'd0) ? 16'h0000 : regs[rs1];
  assign rd2 = (rs2 == 3'd0) ? 16'h0000 : regs[rs2];

  // A source matching the executing destination would read a stale register value.
  assign hazard1 = ex_valid && (ex_rd != 3'd0) && (rs1 == ex_rd);
  assign hazard2 = ex_valid && (ex_rd != 3'd0) && (rs2 == ex_rd);

`ifdef ALU_ISSUE_BYPASS_EN
  assign stall  = 1'b0;
  assign opnd_a = hazard1 ? alu_o : rd1;
  assign opnd_b = hazard2 ? alu_o : rd2;
`else
  assign stall  = hazard1 || hazard2;
  assign opnd_a = rd1;
  assign opnd_b = rd2;
`endif

  assign ins_ready = !reset && !wr_en && !stall;
  assign issue     = ins_valid && ins_ready;

  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

  // Writeback is placed after the external load so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
      alu_op    <= 2'b00;
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      ex_valid  <= 1'b0;
      ex_rd     <= 3'd0;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
      res_cout  <= 1'b0;
      res_rd    <= 3'd0;
    end else begin
      if (wr_en && (wr_addr != 3'd0)) begin
        regs[wr_addr] <= wr_data;
      end
      if (ex_valid && (ex_rd != 3'd0)) begin
        regs[ex_rd] <= alu_o;
      end
      ex_valid <= issue;
      if (issue) begin
        alu_op <= op;
        alu_a  <= opnd_a;
        alu_b  <= opnd_b;
        ex_rd  <= rd;
      end
      res_valid <= ex_valid;
      if (ex_valid) begin
        res_data <= alu_o;
        res_cout <= alu_cout;
        res_rd   <= ex_rd;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed table, corner-case sequences and random traffic for alu_issue.
// Follows ALU_ISSUE_BYPASS_EN the same way as the design build.
module tb_alu_issue;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [10:0] ins = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_o;
  logic        alu_cout;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_cout;
  logic [2:0]  res_rd;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail = 0;

  alu_issue dut (
    .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout), .res_rd(res_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU; logic ops report carry 0.
  always_comb begin
    logic [16:0] t;
    t = 17'h0;
    case (alu_op)
      2'b00:   t = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   t = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      2'b10:   t = {1'b0, alu_a & alu_b};
      default: t = {1'b0, alu_a | alu_b};
    endcase
    alu_o    = t[15:0];
    alu_cout = t[16];
  end

  // Architectural model: committed registers plus the single result still in flight.
  logic [15:0] mregs [0:7];
  logic        pend_v;
  logic [2:0]  pend_rd;
  logic [15:0] pend_val;
  logic        pend_c;
  logic        last_ready;

  function automatic void alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c);
    int unsigned s;
    case (op)
      2'd0: begin s = a + b; r = s[15:0]; c = (s > 32'd65535); end
      2'd1: begin r = a - b; c = (a >= b); end
      2'd2: begin r = a & b; c = 1'b0; end
      default: begin r = a | b; c = 1'b0; end
    endcase
  endfunction

  function automatic logic [15:0] mread(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : mregs[a];
  endfunction

  function automatic logic [15:0] opnd(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (pend_v && pend_rd == a) return pend_val;
    return mregs[a];
  endfunction

  function automatic logic [10:0] mk(input int op, input int rd, input int s1, input int s2);
    logic [10:0] v;
    v = {op[1:0], rd[2:0], s1[2:0], s2[2:0]};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < 8; k++) mregs[k] = 16'h0000;
    pend_v = 1'b0;
    pend_rd = 3'd0;
    pend_val = 16'h0000;
    pend_c = 1'b0;
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check post-edge outputs.
  task automatic applyStimulus(input logic v, input logic [10:0] i, input logic we,
                               input logic [2:0] wa, input logic [15:0] wd, input logic [2:0] da);
    logic haz, exp_ready, do_issue, nc, exp_rv, exp_c;
    logic [15:0] nr, exp_data;
    logic [2:0] exp_rd;
    ins_valid = v; ins = i; wr_en = we; wr_addr = wa; wr_data = wd; dbg_addr = da;
    #1;
    haz = pend_v && pend_rd != 3'd0 && (i[5:3] == pend_rd || i[2:0] == pend_rd);
    exp_ready = !we && !(haz && !BYP);
    last_ready = ins_ready;
    checkOutput("ins_ready", {15'd0, ins_ready}, {15'd0, exp_ready});
    do_issue = v && exp_ready;
    nr = 16'h0; nc = 1'b0;
    if (do_issue) alu_ref(i[10:9], opnd(i[5:3]), opnd(i[2:0]), nr, nc);
    if (we && wa != 3'd0) mregs[wa] = wd;
    if (pend_v && pend_rd != 3'd0) mregs[pend_rd] = pend_val;
    exp_rv = pend_v; exp_data = pend_val; exp_c = pend_c; exp_rd = pend_rd;
    pend_v = do_issue; pend_rd = i[8:6]; pend_val = nr; pend_c = nc;
    @(posedge clk);
    #1;
    checkOutput("res_valid", {15'd0, res_valid}, {15'd0, exp_rv});
    if (exp_rv) begin
      checkOutput("res_data", res_data, exp_data);
      checkOutput("res_cout", {15'd0, res_cout}, {15'd0, exp_c});
      checkOutput("res_rd", {13'd0, res_rd}, {13'd0, exp_rd});
    end
    checkOutput("dbg_data", dbg_data, mread(da));
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1; ins_valid = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      #1;
      checkOutput("ready_in_reset", {15'd0, ins_ready}, 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("res_valid_reset", {15'd0, res_valid}, 16'h0000);
    end
    clearModel();
    reset = 1'b0;
    checkOutput("res_data_reset", res_data, 16'h0000);
    checkOutput("res_cout_reset", {15'd0, res_cout}, 16'h0000);
    checkOutput("res_rd_reset", {13'd0, res_rd}, 16'h0000);
    checkOutput("alu_op_reset", {14'd0, alu_op}, 16'h0000);
    checkOutput("alu_a_reset", alu_a, 16'h0000);
    checkOutput("alu_b_reset", alu_b, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      dbg_addr = k[2:0];
      #1;
      checkOutput("dbg_reset", dbg_data, 16'h0000);
    end
  endtask

  typedef struct {
    logic        v;
    logic [10:0] i;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  da;
    logic        e_rv;
    logic [15:0] e_data;
    logic        e_cout;
    logic [2:0]  e_rd;
    logic [15:0] e_dbg;
  } vec_t;

  function automatic vec_t mkvec(input logic v, input logic [10:0] i, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic [2:0] da, input logic e_rv,
                                 input logic [15:0] e_data, input logic e_cout, input logic [2:0] e_rd,
                                 input logic [15:0] e_dbg);
    vec_t t;
    t.v = v; t.i = i; t.we = we; t.wa = wa; t.wd = wd; t.da = da;
    t.e_rv = e_rv; t.e_data = e_data; t.e_cout = e_cout; t.e_rd = e_rd; t.e_dbg = e_dbg;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [12];
    int drops;
    bit found;

    tbl[0]  = mkvec(0, 11'd0,       1, 3'd1, 16'haa55, 3'd1, 0, 16'h0000, 0, 3'd0, 16'haa55);
    tbl[1]  = mkvec(0, 11'd0,       1, 3'd2, 16'h55aa, 3'd2, 0, 16'h0000, 0, 3'd0, 16'h55aa);
    tbl[2]  = mkvec(1, mk(0,3,1,2), 0, 3'd0, 16'h0000, 3'd3, 0, 16'h0000, 0, 3'd0, 16'h0000);
    tbl[3]  = mkvec(1, mk(1,4,1,2), 0, 3'd0, 16'h0000, 3'd3, 1, 16'hffff, 0, 3'd3, 16'hffff);
    tbl[4]  = mkvec(1, mk(2,5,1,2), 0, 3'd0, 16'h0000, 3'd4, 1, 16'h54ab, 1, 3'd4, 16'h54ab);
    tbl[5]  = mkvec(1, mk(3,6,1,2), 0, 3'd0, 16'h0000, 3'd5, 1, 16'h0000, 0, 3'd5, 16'h0000);
    tbl[6]  = mkvec(0, 11'd0,       0, 3'd0, 16'h0000, 3'd6, 1, 16'hffff, 0, 3'd6, 16'hffff);
    tbl[7]  = mkvec(0, 11'd0,       0, 3'd0, 16'h0000, 3'd6, 0, 16'h0000, 0, 3'd0, 16'hffff);
    tbl[8]  = mkvec(1, mk(0,0,1,2), 0, 3'd0, 16'h0000, 3'd0, 0, 16'h0000, 0, 3'd0, 16'h0000);
    tbl[9]  = mkvec(1, mk(0,1,0,0), 0, 3'd0, 16'h0000, 3'd0, 1, 16'hffff, 0, 3'd0, 16'h0000);
    tbl[10] = mkvec(0, 11'd0,       0, 3'd0, 16'h0000, 3'd1, 1, 16'h0000, 0, 3'd1, 16'h0000);
    tbl[11] = mkvec(0, 11'd0,       0, 3'd0, 16'h0000, 3'd2, 0, 16'h0000, 0, 3'd0, 16'h55aa);

    clearModel();
    @(negedge clk);
    applyReset(2);

    for (int n = 0; n < 12; n++) begin
      applyStimulus(tbl[n].v, tbl[n].i, tbl[n].we, tbl[n].wa, tbl[n].wd, tbl[n].da);
      checkOutput("tbl_res_valid", {15'd0, res_valid}, {15'd0, tbl[n].e_rv});
      if (tbl[n].e_rv) begin
        checkOutput("tbl_res_data", res_data, tbl[n].e_data);
        checkOutput("tbl_res_cout", {15'd0, res_cout}, {15'd0, tbl[n].e_cout});
        checkOutput("tbl_res_rd", {13'd0, res_rd}, {13'd0, tbl[n].e_rd});
      end
      checkOutput("tbl_dbg", dbg_data, tbl[n].e_dbg);
    end

    // Dependent pair: r3 = r1 + r2 then r7 = r3 + r1.
    applyStimulus(0, 11'd0, 1, 3'd1, 16'haa55, 3'd1);
    applyStimulus(1, mk(0,3,1,2), 0, 3'd0, 16'h0, 3'd3);
    drops = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, mk(0,7,3,1), 0, 3'd0, 16'h0, 3'd7);
      if (last_ready) break;
      drops++;
    end
    checkOutput("dep_ready_drops", drops[15:0], BYP ? 16'd0 : 16'd1);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      applyStimulus(0, 11'd0, 0, 3'd0, 16'h0, 3'd7);
      if (res_valid && res_rd == 3'd7) begin
        found = 1'b1;
        checkOutput("dep_r7_data", res_data, 16'haa54);
        checkOutput("dep_r7_cout", {15'd0, res_cout}, 16'h0001);
        checkOutput("dep_r7_dbg", dbg_data, 16'haa54);
      end
    end
    checkOutput("dep_r7_seen", {15'd0, found}, 16'h0001);

    // Load colliding with writeback to r3: writeback must win, ready low during the load.
    applyStimulus(0, 11'd0, 1, 3'd3, 16'h0001, 3'd3);
    applyStimulus(1, mk(0,3,1,2), 0, 3'd0, 16'h0, 3'd3);
    applyStimulus(1, mk(3,6,1,1), 1, 3'd3, 16'h1234, 3'd3);
    checkOutput("collide_ready", {15'd0, last_ready}, 16'h0000);
    checkOutput("collide_r3", dbg_data, 16'hffff);
    applyStimulus(1, mk(0,4,1,2), 0, 3'd0, 16'h0, 3'd4);
    applyStimulus(0, 11'd0, 1, 3'd5, 16'h0bad, 3'd5);
    checkOutput("diff_load_r5", dbg_data, 16'h0bad);
    applyStimulus(0, 11'd0, 0, 3'd0, 16'h0, 3'd4);
    checkOutput("diff_wb_r4", dbg_data, 16'hffff);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 11'($urandom), $urandom_range(0, 4) == 0,
                    3'($urandom), 16'($urandom), 3'($urandom));
    end
    applyStimulus(0, 11'd0, 0, 3'd0, 16'h0, 3'd3);
    applyStimulus(0, 11'd0, 0, 3'd0, 16'h0, 3'd3);

    // Reset the cycle after issuing: the in-flight add must vanish.
    applyStimulus(0, 11'd0, 1, 3'd1, 16'h0101, 3'd1);
    applyStimulus(1, mk(0,3,1,1), 0, 3'd0, 16'h0, 3'd3);
    applyReset(1);
    dbg_addr = 3'd3;
    #1;
    checkOutput("reset_mid_r3", dbg_data, 16'h0000);
    applyStimulus(0, 11'd0, 0, 3'd0, 16'h0, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
